// File: rtl/axil_mem_pkg.sv
// Shared types for the AXI4-Lite parametrised memory slave: response codes,
// FSM states, address regions and fixed CSR indices.
package axil_mem_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rd_state_t;
   typedef enum logic       {W_IDLE, W_RESP}          wr_state_t;

   typedef enum logic [1:0] {REGION_NONE, REGION_CSR, REGION_MEM} region_t;

   localparam int CSR_ID     = 0;
   localparam int CSR_ERRCNT = 1;

endpackage

// File: rtl/axil_mem_array.sv
// Single-clock word memory: sync read, byte-enable write. With AXIL_MEM_PARITY_EN
// defined, one even-parity bit per byte is stored alongside and checked on read.
module axil_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic [DATA_W/8-1:0]        we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]          rdata,
   output logic                       par_err
);
   localparam int STRB_W = DATA_W/8;

   logic [STRB_W-1:0][7:0] mem [DEPTH];

   // Read and write share one block so a same-edge collision returns the old word.
   always_ff @(posedge clk) begin
      for (int b = 0; b < STRB_W; b++)
         if (we[b]) mem[waddr][b] <= wdata[b*8 +: 8];
      if (re) rdata <= mem[raddr];
   end

`ifdef AXIL_MEM_PARITY_EN
   logic [STRB_W-1:0] par_mem [DEPTH];
   logic [STRB_W-1:0] rpar;
   logic [STRB_W-1:0] par_calc;

   always_ff @(posedge clk) begin
      for (int b = 0; b < STRB_W; b++)
         if (we[b]) par_mem[waddr][b] <= ^wdata[b*8 +: 8];
      if (re) rpar <= par_mem[raddr];
   end

   always_comb begin
      par_calc = '0;
      for (int b = 0; b < STRB_W; b++)
         par_calc[b] = ^rdata[b*8 +: 8];
   end

   assign par_err = |(par_calc ^ rpar);
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: rtl/axil_param_mem_slave.sv
// AXI4-Lite slave: CSR window (ID, saturating error counter, scratch) plus a
// byte-writable memory window. Optional read parity check via AXIL_MEM_PARITY_EN.
module axil_param_mem_slave
   import axil_mem_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                NUM_REGS  = 4,
   parameter logic [ADDR_W-1:0] MEM_BASE  = 'h100,
   parameter int                MEM_DEPTH = 256,
   parameter logic [DATA_W-1:0] ID_VALUE  = 'hA11E_0001
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready
);
   localparam int STRB_W = DATA_W/8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam int CSR_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W-1:0] CSR_END = ADDR_W'(NUM_REGS*STRB_W);
   localparam logic [ADDR_W-1:0] MEM_END = MEM_BASE + ADDR_W'(MEM_DEPTH*STRB_W);

   function automatic region_t decode(input logic [ADDR_W-1:0] a);
      if (a < CSR_END) return REGION_CSR;
      if (a >= MEM_BASE && a < MEM_END) return REGION_MEM;
      return REGION_NONE;
   endfunction

   // MEM_BASE need not be aligned to the window size, so index from the offset.
   function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_W-1:0] a);
      return MEM_AW'((a - MEM_BASE) >> LSB);
   endfunction

   logic                   live;
   logic [DATA_W-1:0]      err_cnt;
   logic [STRB_W-1:0][7:0] csr [NUM_REGS];

   // Read side
   rd_state_t         rd_state, rd_next;
   logic [ADDR_W-1:0] ar_addr;
   region_t           rd_region;
   logic [CSR_IW-1:0] rd_idx;
   logic [DATA_W-1:0] csr_rd, csr_rdata_q, mem_rdata;
   logic              par_err;

   // Write side
   wr_state_t         wr_state, wr_next;
   logic              aw_held, w_held, wr_fire, wr_csr_ro;
   logic [ADDR_W-1:0] aw_addr;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   region_t           wr_region;
   logic [CSR_IW-1:0] wr_idx;
   resp_t             wr_resp, bresp_q;

   assign rd_region = decode(ar_addr);
   assign rd_idx    = CSR_IW'(ar_addr >> LSB);
   assign wr_region = decode(aw_addr);
   assign wr_idx    = CSR_IW'(aw_addr >> LSB);
   assign wr_csr_ro = (wr_idx == CSR_IW'(CSR_ID)) || (wr_idx == CSR_IW'(CSR_ERRCNT));
   assign wr_fire   = (wr_state == W_IDLE) && aw_held && w_held;
   assign bresp     = bresp_q;

   always_comb begin
      csr_rd = csr[rd_idx];
      if (rd_idx == CSR_IW'(CSR_ID))          csr_rd = ID_VALUE;
      else if (rd_idx == CSR_IW'(CSR_ERRCNT)) csr_rd = err_cnt;
   end

   always_comb begin
      wr_resp = OKAY;
      if (wr_region == REGION_NONE)                  wr_resp = DECERR;
      else if (wr_region == REGION_CSR && wr_csr_ro) wr_resp = SLVERR;
   end

   // Holds every ready low for the first cycle out of reset.
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) live <= 1'b0;
      else          live <= 1'b1;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state    <= R_IDLE;
         ar_addr     <= '0;
         csr_rdata_q <= '0;
      end else begin
         rd_state <= rd_next;
         if (arvalid && arready)   ar_addr     <= araddr;
         if (rd_state == R_FETCH)  csr_rdata_q <= csr_rd;
      end
   end

   always_comb begin
      rd_next = rd_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = OKAY;
      case (rd_state)
         R_IDLE: begin
            arready = live;
            if (arvalid && live) rd_next = R_FETCH;
         end
         R_FETCH: rd_next = R_RESP;
         R_RESP: begin
            rvalid = 1'b1;
            case (rd_region)
               REGION_CSR: rdata = csr_rdata_q;
               REGION_MEM: begin
                  rdata = mem_rdata;
                  if (par_err) rresp = SLVERR;
               end
               default:    rresp = DECERR;
            endcase
            if (rready) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state <= W_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_addr  <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         bresp_q  <= OKAY;
         for (int i = 0; i < NUM_REGS; i++) csr[i] <= '0;
      end else begin
         wr_state <= wr_next;
         if (awvalid && awready) begin
            aw_held <= 1'b1;
            aw_addr <= awaddr;
         end
         if (wvalid && wready) begin
            w_held <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
         end
         if (wr_fire) bresp_q <= wr_resp;
         if (wr_fire && wr_region == REGION_CSR && !wr_csr_ro)
            for (int b = 0; b < STRB_W; b++)
               if (w_strb[b]) csr[wr_idx][b] <= w_data[b*8 +: 8];
         if (bvalid && bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= OKAY;
         end
      end
   end

   always_comb begin
      wr_next = wr_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            awready = live && !aw_held;
            wready  = live && !w_held;
            if (aw_held && w_held) wr_next = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // Errors are counted when their response handshakes; R and B on one edge add 2.
   logic          rd_err, wr_err;
   logic [DATA_W:0] err_sum;
   assign rd_err  = rvalid && rready && (rresp != OKAY);
   assign wr_err  = bvalid && bready && (bresp != OKAY);
   assign err_sum = {1'b0, err_cnt} + (DATA_W+1)'(rd_err) + (DATA_W+1)'(wr_err);

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) err_cnt <= '0;
      else          err_cnt <= err_sum[DATA_W] ? '1 : err_sum[DATA_W-1:0];

   axil_mem_array #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH)) u_mem (
      .clk     (aclk),
      .we      ((wr_fire && wr_region == REGION_MEM) ? w_strb : '0),
      .waddr   (mem_idx(aw_addr)),
      .wdata   (w_data),
      .re      ((rd_state == R_FETCH) && (rd_region == REGION_MEM)),
      .raddr   (mem_idx(ar_addr)),
      .rdata   (mem_rdata),
      .par_err (par_err)
   );

endmodule

// File: tb/tb_axil_param_mem_slave.sv
// Scoreboard bench for axil_param_mem_slave: stimulus pushes expected R/B
// responses, a negedge monitor pops and compares at each handshake.
module tb_axil_param_mem_slave;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
   logic        rready = 1'b1, bready = 1'b1;
   logic [3:0]  wstrb = '0;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   logic [33:0] rd_q [$];
   logic [1:0]  wr_q [$];
   int n_chk = 0, n_pass = 0;

`ifdef AXIL_MEM_PARITY_EN
   localparam int PAR_ERRS = 1;
`else
   localparam int PAR_ERRS = 0;
`endif

   axil_param_mem_slave dut (
      .aclk(aclk), .aresetn(aresetn),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic tmo(input string nm);
      n_chk++;
      $display("FAIL %s: got timeout want response", nm);
   endtask

   always @(negedge aclk) if (aresetn) begin
      if (rvalid && rready) begin
         if (rd_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
         else begin
            logic [33:0] e;
            e = rd_q.pop_front();
            chk("rdata", 64'(rdata), 64'(e[31:0]));
            chk("rresp", 64'(rresp), 64'(e[33:32]));
         end
      end
      if (bvalid && bready) begin
         if (wr_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
         else chk("bresp", 64'(bresp), 64'(wr_q.pop_front()));
      end
   end

   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      bit ok = 0;
      rd_q.push_back({r, d});
      @(posedge aclk); #1;
      arvalid = 1'b1; araddr = a;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (arready) begin ok = 1; break; end
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      if (!ok) tmo("ar_handshake");
   endtask

   // w_lead=1 presents W one cycle before AW; 0 presents both together.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp, input int w_lead);
      bit aw_done = 0, w_done = 0, aw_go, w_go;
      wr_q.push_back(exp);
      @(posedge aclk); #1;
      wvalid = 1'b1; wdata = d; wstrb = s;
      if (w_lead == 0) begin awvalid = 1'b1; awaddr = a; end
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         @(negedge aclk);
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(posedge aclk); #1;
         if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
         if (w_go)  begin wvalid  = 1'b0; w_done  = 1; end
         if (!aw_done && !awvalid) begin awvalid = 1'b1; awaddr = a; end
      end
      if (!(aw_done && w_done)) begin
         awvalid = 1'b0; wvalid = 1'b0;
         tmo("aw_w_handshake");
      end
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge aclk);
         if (rd_q.size() == 0 && wr_q.size() == 0) begin ok = 1; break; end
      end
      if (!ok) tmo("drain");
      #1;
   endtask

   task automatic wait_valid(input bit is_r, output bit ok);
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (is_r ? rvalid : bvalid) begin ok = 1; break; end
      end
      if (!ok) tmo(is_r ? "rvalid_wait" : "bvalid_wait");
   endtask

   initial begin
      bit ok;
      // 1: reset state, readies one cycle after release, read latency
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("reset_outputs", 64'({arready, rvalid, rdata, rresp, awready, wready, bresp, bvalid}), 64'd0);
      @(posedge aclk); #1 aresetn = 1'b1;
      @(negedge aclk);
      chk("ready_first_cycle", 64'({arready, awready, wready}), 64'd0);
      @(negedge aclk);
      chk("ready_second_cycle", 64'({arready, awready, wready}), 64'b111);
      rd_q.push_back({2'b00, 32'hA11E_0001});
      @(posedge aclk); #1 arvalid = 1'b1; araddr = 32'h0;
      @(posedge aclk); #1 arvalid = 1'b0;     // handshake edge
      @(negedge aclk); chk("rvalid_fetch_cycle", 64'(rvalid), 64'd0);
      @(negedge aclk); chk("rvalid_resp_cycle", 64'(rvalid), 64'd1);
      drain();

      // 2: W ahead of AW, byte-strobed overwrite, last word and unaligned reads
      do_write(32'h100, 32'hDEADBEEF, 4'hF, 2'b00, 1); drain();
      do_write(32'h100, 32'h0000_1234, 4'h3, 2'b00, 1); drain();
      do_read(32'h100, 32'hDEAD1234, 2'b00); drain();
      do_read(32'h102, 32'hDEAD1234, 2'b00); drain();
      do_write(32'h4FC, 32'hCAFEF00D, 4'hF, 2'b00, 0); drain();
      do_read(32'h4FC, 32'hCAFEF00D, 2'b00); drain();
      do_write(32'h4FC, 32'h1111_1111, 4'h0, 2'b00, 0); drain();
      do_read(32'h4FC, 32'hCAFEF00D, 2'b00); drain();

      // 3: B stall holds bvalid/bresp and keeps AW/W closed
      @(posedge aclk); #1 bready = 1'b0;
      do_write(32'h104, 32'h0000_0001, 4'hF, 2'b00, 0);
      wait_valid(0, ok);
      if (ok) for (int k = 0; k < 5; k++) begin
         chk("b_stall", 64'({bvalid, bresp, awready, wready}), 64'b1_00_0_0);
         @(negedge aclk);
      end
      @(posedge aclk); #1 bready = 1'b1;
      drain();

      // 4: error responses, CSR access and counter
      do_write(32'h0, 32'h1234_5678, 4'hF, 2'b10, 0); drain();      // err 1
      do_read(32'h0, 32'hA11E_0001, 2'b00); drain();
      do_read(32'h5000, 32'h0, 2'b11); drain();                      // err 2
      do_read(32'h4, 32'd2, 2'b00); drain();
      do_write(32'h8, 32'h1122_3344, 4'h5, 2'b00, 0); drain();
      do_read(32'h8, 32'h0022_0044, 2'b00); drain();
      do_read(32'h10, 32'h0, 2'b11); drain();                        // err 3
      do_read(32'h500, 32'h0, 2'b11); drain();                       // err 4
      do_write(32'h5000, 32'hFFFF_FFFF, 4'hF, 2'b11, 0); drain();    // err 5
      do_write(32'h4, 32'h0, 4'hF, 2'b10, 0); drain();               // err 6
      do_read(32'h4, 32'd6, 2'b00); drain();

      // 5: same-edge read and commit of 0x104 returns old data; R stall holds rdata
      @(posedge aclk); #1 rready = 1'b0;
      fork
         do_write(32'h104, 32'h0000_0002, 4'hF, 2'b00, 0);
         do_read(32'h104, 32'h0000_0001, 2'b00);
      join
      wait_valid(1, ok);
      if (ok) for (int k = 0; k < 3; k++) begin
         chk("r_stall", 64'({rvalid, rresp, rdata}), {29'd0, 1'b1, 2'b00, 32'h1});
         @(negedge aclk);
      end
      @(posedge aclk); #1 rready = 1'b1;
      drain();
      do_read(32'h104, 32'h0000_0002, 2'b00); drain();

`ifdef AXIL_MEM_PARITY_EN
      // 6: corrupted parity gives SLVERR with the stored data
      do_write(32'h108, 32'h55AA_00FF, 4'hF, 2'b00, 0); drain();
      dut.u_mem.par_mem[2][0] = ~dut.u_mem.par_mem[2][0];
      do_read(32'h108, 32'h55AA_00FF, 2'b10); drain();
      do_read(32'h4, 32'd7, 2'b00); drain();
`endif

      // R and B errors on the same edge add 2
      fork
         do_write(32'h5000, 32'h0, 4'hF, 2'b11, 0);
         do_read(32'h5000, 32'h0, 2'b11);
      join
      drain();
      do_read(32'h4, 32'(8 + PAR_ERRS), 2'b00); drain();

      // Saturation: a +2 from all-ones-minus-one clamps, further errors leave it
      force dut.err_cnt = 32'hFFFF_FFFE;
      @(posedge aclk); #1 release dut.err_cnt;
      fork
         do_write(32'h5000, 32'h0, 4'hF, 2'b11, 0);
         do_read(32'h5000, 32'h0, 2'b11);
      join
      drain();
      do_read(32'h4, 32'hFFFF_FFFF, 2'b00); drain();
      do_write(32'h0, 32'h0, 4'hF, 2'b10, 0); drain();
      do_read(32'h4, 32'hFFFF_FFFF, 2'b00); drain();

      repeat (2) @(posedge aclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
